// File: rtl/prior_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// prior_arbiter_ctrl
//
// Purpose:
//   Sequential arbiter that hands a shared resource (bus, ALU, memory port)
//   to one of N requesters. A grant is held until the owner signals done,
//   withdraws its request, or reaches the hold limit. Every grant is followed
//   by exactly one dead cycle (GAP) before the next grant can appear, so the
//   datapath select mux driven by gnt_id never switches owners back-to-back.
//
// Build option:
//   ROUND_ROBIN_EN  defined   -> rotating priority. The search starts just
//                                below the most recent owner and wraps modulo
//                                N, so the last owner has the lowest priority.
//                   undefined -> fixed priority, the highest index wins.
//   The port list and the cycle timing are the same in both builds.
//
// Parameters:
//   N         number of requesters (2..32)
//   ID_W      width of gnt_id, equal to clog2(N)
//   MAX_HOLD  maximum number of cycles a grant stays visible (2..255)
//
// Ports:
//   clk        in   1     rising-edge clock
//   rst        in   1     asynchronous reset, active-high
//   req        in   N     request vector, req[i]=1 -> requester i wants access
//   done       in   1     current owner finished (looked at only in GRANT)
//   gnt        out  N     one-hot grant, registered
//   gnt_id     out  ID_W  binary index of the owner, 0 when gnt_valid=0
//   gnt_valid  out  1     high while a grant is active (equals |gnt)
//   timeout    out  1     one-cycle pulse when the hold limit revoked a grant
// ---------------------------------------------------------------------------
module prior_arbiter_ctrl #(
  parameter int N        = 8,
  parameter int ID_W     = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  // Last legal hold count value; reaching it while still granted revokes.
  localparam logic [7:0]   HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [N-1:0] ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  // Registered state and outputs
  state_t          state_r;
  logic [N-1:0]    gnt_r;
  logic [ID_W-1:0] gnt_id_r;
  logic            gnt_valid_r;
  logic            timeout_r;
  logic [7:0]      hold_cnt_r;
  logic [ID_W-1:0] last_id_r;

  // Next-state values
  state_t          state_s;
  logic [N-1:0]    gnt_s;
  logic [ID_W-1:0] gnt_id_s;
  logic            gnt_valid_s;
  logic            timeout_s;
  logic [7:0]      hold_cnt_s;
  logic [ID_W-1:0] last_id_s;

  // Arbitration result
  logic            any_req_s;
  logic [ID_W-1:0] win_s;

`ifdef ROUND_ROBIN_EN
  localparam logic [ID_W:0] N_W = (ID_W+1)'(N);

  // Rotating search: last-1, last-2, ... wrapping modulo N, ending at last.
  // The index is formed one bit wider than ID_W so last+N never overflows.
  function automatic logic [ID_W-1:0] pick_winner(
    input logic [N-1:0]    r,
    input logic [ID_W-1:0] last
  );
    logic [ID_W-1:0] w;
    logic            found;
    logic [ID_W:0]   t;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      t = {1'b0, last} + N_W - (ID_W+1)'(k);
      if (t >= N_W) begin
        t = t - N_W;
      end else begin
        t = t;
      end
      if (!found && r[t[ID_W-1:0]]) begin
        w     = t[ID_W-1:0];
        found = 1'b1;
      end else begin
        w     = w;
        found = found;
      end
    end
    return w;
  endfunction

  // Winner selection with rotating priority
  always_comb begin
    win_s = pick_winner(req, last_id_r);
  end
`else
  // Fixed priority: the last set bit seen while scanning upward is the
  // highest index, which is the winner.
  function automatic logic [ID_W-1:0] pick_winner(input logic [N-1:0] r);
    logic [ID_W-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        w = ID_W'(i);
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  // last_id is still tracked in this build but does not steer selection.
  logic unused_last_id;
  assign unused_last_id = ^last_id_r;

  // Winner selection with fixed priority
  always_comb begin
    win_s = pick_winner(req);
  end
`endif

  assign any_req_s = |req;

  // Next-state and next-output computation
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    gnt_id_s    = gnt_id_r;
    gnt_valid_s = gnt_valid_r;
    timeout_s   = 1'b0;
    hold_cnt_s  = hold_cnt_r;
    last_id_s   = last_id_r;

    case (state_r)
      // IDLE and GAP arbitrate identically; GAP simply always leaves.
      ST_IDLE, ST_GAP: begin
        if (any_req_s) begin
          state_s     = ST_GRANT;
          gnt_s       = ONE_HOT0 << win_s;
          gnt_id_s    = win_s;
          gnt_valid_s = 1'b1;
          hold_cnt_s  = 8'd0;
        end else begin
          state_s     = ST_IDLE;
          gnt_s       = '0;
          gnt_id_s    = '0;
          gnt_valid_s = 1'b0;
        end
      end

      // Release conditions in priority order: done, withdrawal, hold limit.
      // Other requesters are ignored here (no preemption).
      ST_GRANT: begin
        if (done) begin
          state_s     = ST_GAP;
          gnt_s       = '0;
          gnt_id_s    = '0;
          gnt_valid_s = 1'b0;
          last_id_s   = gnt_id_r;
        end else if (!req[gnt_id_r]) begin
          state_s     = ST_GAP;
          gnt_s       = '0;
          gnt_id_s    = '0;
          gnt_valid_s = 1'b0;
          last_id_s   = gnt_id_r;
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s     = ST_GAP;
          gnt_s       = '0;
          gnt_id_s    = '0;
          gnt_valid_s = 1'b0;
          timeout_s   = 1'b1;
          last_id_s   = gnt_id_r;
        end else begin
          state_s     = ST_GRANT;
          hold_cnt_s  = hold_cnt_r + 8'd1;
        end
      end

      // Unused encoding: fall back to IDLE with everything cleared.
      default: begin
        state_s     = ST_IDLE;
        gnt_s       = '0;
        gnt_id_s    = '0;
        gnt_valid_s = 1'b0;
        timeout_s   = 1'b0;
        hold_cnt_s  = 8'd0;
        last_id_s   = '0;
      end
    endcase
  end

  // State and output registers, cleared immediately by rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      gnt_r       <= '0;
      gnt_id_r    <= '0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
      hold_cnt_r  <= 8'd0;
      last_id_r   <= '0;
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      gnt_id_r    <= gnt_id_s;
      gnt_valid_r <= gnt_valid_s;
      timeout_r   <= timeout_s;
      hold_cnt_r  <= hold_cnt_s;
      last_id_r   <= last_id_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_id    = gnt_id_r;
  assign gnt_valid = gnt_valid_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_prior_arbiter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prior_arbiter_ctrl
//
// Directed bench for prior_arbiter_ctrl (N=8, ID_W=3, MAX_HOLD=16).
// Inputs change on the falling edge; outputs are checked on the falling
// edge after the rising edge that should have updated them.
// ---------------------------------------------------------------------------
module tb_prior_arbiter_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int vectors;
  int miscompares;

  prior_arbiter_ctrl #(
    .N        (8),
    .ID_W     (3),
    .MAX_HOLD (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Checks all four outputs against expected values.
  task automatic chk_all(input string tag, input logic [7:0] g, input logic [2:0] id,
                         input logic v, input logic to);
    chk({tag, " gnt"},       32'(gnt),       32'(g));
    chk({tag, " gnt_id"},    32'(gnt_id),    32'(id));
    chk({tag, " gnt_valid"}, 32'(gnt_valid), 32'(v));
    chk({tag, " timeout"},   32'(timeout),   32'(to));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] exp_id;
    vectors     = 0;
    miscompares = 0;
    rst  = 1'b1;
    req  = 8'h00;
    done = 1'b0;

    // Reset state
    tick();
    tick();
    chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk_all("idle no req", 8'h00, 3'd0, 1'b0, 1'b0);

    // T1: highest requester (5) wins one cycle later
    req = 8'b0010_0110;
    tick();
    chk_all("T1 grant", 8'h20, 3'd5, 1'b1, 1'b0);

    // T2: other requests ignored while granted, done on 3rd cycle
    tick();
    chk_all("T2 hold c2", 8'h20, 3'd5, 1'b1, 1'b0);
    tick();
    chk_all("T2 hold c3", 8'h20, 3'd5, 1'b1, 1'b0);
    done = 1'b1;
    req  = 8'b0000_0110;
    tick();
    chk_all("T2 gap", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    tick();
    chk_all("T2 regrant", 8'h04, 3'd2, 1'b1, 1'b0);

    // Withdrawal of owner 2, then idle
    req = 8'h00;
    tick();
    chk_all("wd gap", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_all("wd idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // T4: grant to 6, req[6] dropped while others are present
    req = 8'h40;
    tick();
    chk_all("T4 grant", 8'h40, 3'd6, 1'b1, 1'b0);
    req = 8'h0A;
    tick();
    chk_all("T4 drop", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_all("T4 next", 8'h08, 3'd3, 1'b1, 1'b0);

    // T3: req[3] held, grant visible exactly 16 cycles, then timeout pulse
    req = 8'h08;
    for (int c = 2; c <= 16; c++) begin
      tick();
      chk_all("T3 held", 8'h08, 3'd3, 1'b1, 1'b0);
    end
    tick();
    chk_all("T3 timeout", 8'h00, 3'd0, 1'b0, 1'b1);
    tick();
    chk_all("T3 regrant", 8'h08, 3'd3, 1'b1, 1'b0);

    // done on the hold-limit cycle wins: no timeout pulse
    for (int c = 2; c <= 16; c++) begin
      tick();
    end
    chk_all("limit last cycle", 8'h08, 3'd3, 1'b1, 1'b0);
    done = 1'b1;
    tick();
    chk_all("done beats timeout", 8'h00, 3'd0, 1'b0, 1'b0);
    done = 1'b0;
    req  = 8'h00;
    tick();
    chk_all("back to idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // T5: asynchronous reset between edges drops the grant at once
    req = 8'h10;
    tick();
    chk_all("T5 grant", 8'h10, 3'd4, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("T5 async rst", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req = 8'hFF;
    chk_all("T5 released", 8'h00, 3'd0, 1'b0, 1'b0);
    tick();
    chk_all("T6 first", 8'h80, 3'd7, 1'b1, 1'b0);

    // T6: all requesting, done pulsed each grant
    for (int g = 1; g <= 8; g++) begin
      done = 1'b1;
      tick();
      chk("T6 gap valid", 32'(gnt_valid), 32'd0);
      done = 1'b0;
      tick();
`ifdef ROUND_ROBIN_EN
      exp_id = 3'((15 - g) % 8);
`else
      exp_id = 3'd7;
`endif
      chk("T6 gnt_id", 32'(gnt_id), 32'(exp_id));
      chk("T6 gnt", 32'(gnt), 32'(8'h01 << exp_id));
      chk("T6 valid", 32'(gnt_valid), 32'd1);
    end

    req = 8'h00;
    tick();
    chk_all("end gap", 8'h00, 3'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
